// File: rtl/sisc_lsu_if.sv
// Request/response and data-memory bus of the SISC load/store unit.
// master = control unit plus data memory side, slave = the LSU itself.
interface sisc_lsu_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              start;
  logic              op_st;
  logic [DATA_W-1:0] base;
  logic [15:0]       offset;
  logic [DATA_W-1:0] st_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] ld_data;
  logic              addr_err;
  logic [ADDR_W-1:0] dm_read_addr;
  logic [ADDR_W-1:0] dm_write_addr;
  logic [DATA_W-1:0] dm_write_data;
  logic              dm_we;
  logic [DATA_W-1:0] dm_read_data;

  modport master (
    output start, op_st, base, offset, st_data, dm_read_data,
    input  busy, done, ld_data, addr_err,
    input  dm_read_addr, dm_write_addr, dm_write_data, dm_we
  );

  modport slave (
    input  start, op_st, base, offset, st_data, dm_read_data,
    output busy, done, ld_data, addr_err,
    output dm_read_addr, dm_write_addr, dm_write_data, dm_we
  );
endinterface

// File: rtl/sisc_lsu.sv
// SISC load/store unit: one request at a time, 3 cycles per request,
// sole driver of the data memory (writes commit on the dm_we fall).
module sisc_lsu #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_ADDR = 65532
) (
  input  logic     clk,
  input  logic     rst,
  sisc_lsu_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, LD_WAIT, LD_CAP, ST_SET, ST_PULSE, DONE
  } state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_ld_data;
  logic              r_addr_err;
  logic              r_err;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_we;

  logic [ADDR_W-1:0] w_ea;
  logic              w_err;
  logic              w_unused;

  // EA wraps modulo 2^ADDR_W; base bits above the address width are ignored
  assign w_ea     = bus.base[ADDR_W-1:0] + ADDR_W'($signed(bus.offset));
  assign w_err    = (w_ea > ADDR_W'(MAX_ADDR));
  assign w_unused = &{1'b0, bus.base[DATA_W-1:ADDR_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ld_data  <= '0;
      r_addr_err <= 1'b0;
      r_err      <= 1'b0;
      r_rd_addr  <= '0;
      r_we       <= 1'b0;
      // a write pulse cut by reset still commits, so its address/data must hold
      if (!r_we) begin
        r_wr_addr <= '0;
        r_wr_data <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          if (bus.start) begin
            r_busy <= 1'b1;
            r_err  <= w_err;
            if (bus.op_st) begin
              r_state <= ST_SET;
              if (!w_err) begin
                r_wr_addr <= w_ea;
                r_wr_data <= bus.st_data;
              end
            end else begin
              r_state <= LD_WAIT;
              if (!w_err) r_rd_addr <= w_ea;
            end
          end
        end
        LD_WAIT: begin
          r_state   <= LD_CAP;
          r_ld_data <= r_err ? '0 : bus.dm_read_data;
        end
        LD_CAP: begin
          r_state    <= DONE;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_addr_err <= r_err;
        end
        ST_SET: begin
          r_state <= ST_PULSE;
          r_we    <= ~r_err;
        end
        ST_PULSE: begin
          r_state    <= DONE;
          r_we       <= 1'b0;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_addr_err <= r_err;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.ld_data       = r_ld_data;
  assign bus.addr_err      = r_addr_err;
  assign bus.dm_read_addr  = r_rd_addr;
  assign bus.dm_write_addr = r_wr_addr;
  assign bus.dm_write_data = r_wr_data;
  assign bus.dm_we         = r_we;
endmodule

// File: tb/tb_sisc_lsu.sv
// Directed bench for sisc_lsu: hand sequences for timing corners, then a
// table of load/store vectors against a behavioural data memory.
module tb_sisc_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sisc_lsu_if #(.ADDR_W(16), .DATA_W(32)) bus ();
  sisc_lsu #(.ADDR_W(16), .DATA_W(32), .MAX_ADDR(65532)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [31:0] mem [0:65535];
  bit          mem_en = 1'b0;
  int          wr_cnt = 0;
  assign bus.dm_read_data = mem[bus.dm_read_addr];
  always @(negedge bus.dm_we) begin
    if (mem_en) begin
      mem[bus.dm_write_addr] = bus.dm_write_data;
      wr_cnt++;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start held across one edge; returns 1ns after the accepting edge E
  task automatic issue(input bit op, input logic [31:0] b, input logic [15:0] off,
                       input logic [31:0] d);
    bus.start = 1'b1; bus.op_st = op; bus.base = b; bus.offset = off; bus.st_data = d;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  typedef struct {
    bit          op;
    logic [31:0] base;
    logic [15:0] off;
    logic [31:0] data;
    logic [15:0] ea;
    logic [31:0] exp;   // load: ld_data; store: mem[ea] afterwards
    bit          err;
  } vec_t;
  vec_t vt [10];

  initial begin
    int lat, w0, dones;
    logic [15:0] ra0;
    vt[0] = '{1'b0, 32'h0000_0003, 16'h0002, 32'h0, 16'h0005, 32'h0000_0007, 1'b0};
    vt[1] = '{1'b1, 32'h0000_0010, 16'hFFFF, 32'h1111_2222, 16'h000F, 32'h1111_2222, 1'b0};
    vt[2] = '{1'b0, 32'h0000_0010, 16'hFFFF, 32'h0, 16'h000F, 32'h1111_2222, 1'b0};
    vt[3] = '{1'b0, 32'h0000_FFFF, 16'h0001, 32'h0, 16'h0000, 32'h1234_5678, 1'b0};
    vt[4] = '{1'b1, 32'h0000_FFFC, 16'h0001, 32'h0000_0099, 16'hFFFD, 32'h0000_0055, 1'b1};
    vt[5] = '{1'b0, 32'h0000_FFFC, 16'h0001, 32'h0, 16'hFFFD, 32'h0000_0000, 1'b1};
    vt[6] = '{1'b0, 32'h0001_FFFC, 16'h0000, 32'h0, 16'hFFFC, 32'hCAFE_0001, 1'b0};
    vt[7] = '{1'b1, 32'h0000_0100, 16'h8000, 32'h0BAD_F00D, 16'h8100, 32'h0BAD_F00D, 1'b0};
    vt[8] = '{1'b0, 32'h0000_8000, 16'h0100, 32'h0, 16'h8100, 32'h0BAD_F00D, 1'b0};
    vt[9] = '{1'b0, 32'h0000_0000, 16'hFFFF, 32'h0, 16'hFFFF, 32'h0000_0000, 1'b1};

    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    mem[16'h0005] = 32'h0000_0007;
    mem[16'h0000] = 32'h1234_5678;
    mem[16'hFFFC] = 32'hCAFE_0001;
    mem[16'hFFFD] = 32'h0000_0055;
    bus.start = 1'b0; bus.op_st = 1'b0; bus.base = '0; bus.offset = '0; bus.st_data = '0;

    tick(); tick();
    rst = 1'b0;
    mem_en = 1'b1;
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    chk("rst_ld_data", bus.ld_data, 32'h0);
    chk("rst_addr_err", {31'b0, bus.addr_err}, 32'h0);
    chk("rst_rd_addr", {16'b0, bus.dm_read_addr}, 32'h0);
    chk("rst_we_waddr", {15'b0, bus.dm_we, bus.dm_write_addr}, 32'h0);
    chk("rst_wdata", bus.dm_write_data, 32'h0);

    // basic load: read address presented right after E
    issue(1'b0, 32'h3, 16'd2, 32'h0);
    chk("ld_rd_addr", {16'b0, bus.dm_read_addr}, 32'h5);
    chk("ld_busy", {31'b0, bus.busy}, 32'h1);
    wait_done(lat);
    chk("ld_lat", lat, 2);
    chk("ld_data", bus.ld_data, 32'h7);
    chk("ld_busy_done", {31'b0, bus.busy}, 32'h0);

    // store pulse shape, then a load issued in the DONE cycle
    tick();
    w0 = wr_cnt;
    issue(1'b1, 32'h10, 16'hFFFF, 32'hDEAD_BEEF);
    chk("st_we_E", {31'b0, bus.dm_we}, 32'h0);
    chk("st_waddr_E", {16'b0, bus.dm_write_addr}, 32'h0F);
    tick();
    chk("st_we_E1", {31'b0, bus.dm_we}, 32'h1);
    chk("st_done_E1", {31'b0, bus.done}, 32'h0);
    tick();
    chk("st_we_E2", {31'b0, bus.dm_we}, 32'h0);
    chk("st_done_E2", {31'b0, bus.done}, 32'h1);
    chk("st_mem", mem[16'h0F], 32'hDEAD_BEEF);
    chk("st_wcnt", wr_cnt - w0, 1);
    issue(1'b0, 32'h10, 16'hFFFF, 32'h0);
    chk("b2b_waddr_hold", {16'b0, bus.dm_write_addr}, 32'h0F);
    chk("b2b_busy", {31'b0, bus.busy}, 32'h1);
    chk("b2b_done_low", {31'b0, bus.done}, 32'h0);
    wait_done(lat);
    chk("b2b_lat", lat, 2);
    chk("b2b_ld_data", bus.ld_data, 32'hDEAD_BEEF);

    // start during a store in flight is dropped
    tick();
    w0 = wr_cnt;
    issue(1'b1, 32'h20, 16'h0, 32'h77);
    bus.start = 1'b1; bus.op_st = 1'b1; bus.base = 32'h21; bus.st_data = 32'h88;
    tick();
    bus.start = 1'b0;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done) dones++;
      tick();
    end
    chk("coll_dones", dones, 1);
    chk("coll_wcnt", wr_cnt - w0, 1);
    chk("coll_mem20", mem[16'h20], 32'h77);
    chk("coll_mem21", mem[16'h21], 32'h0);

    // reset while dm_we is high: the requested write still lands
    w0 = wr_cnt;
    issue(1'b1, 32'h30, 16'h0, 32'h0000_ABCD);
    tick();
    chk("rstp_we_hi", {31'b0, bus.dm_we}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstp_we", {31'b0, bus.dm_we}, 32'h0);
    chk("rstp_busy", {31'b0, bus.busy}, 32'h0);
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.done) dones++;
      tick();
    end
    chk("rstp_dones", dones, 0);
    chk("rstp_mem", mem[16'h30], 32'h0000_ABCD);
    chk("rstp_wcnt", wr_cnt - w0, 1);

    // table of loads/stores
    for (int i = 0; i < 10; i++) begin
      w0 = wr_cnt;
      ra0 = bus.dm_read_addr;
      issue(vt[i].op, vt[i].base, vt[i].off, vt[i].data);
      wait_done(lat);
      chk($sformatf("v%0d_lat", i), lat, 2);
      chk($sformatf("v%0d_err", i), {31'b0, bus.addr_err}, {31'b0, vt[i].err});
      if (vt[i].op) begin
        chk($sformatf("v%0d_mem", i), mem[vt[i].ea], vt[i].exp);
        chk($sformatf("v%0d_wcnt", i), wr_cnt - w0, vt[i].err ? 0 : 1);
      end else begin
        chk($sformatf("v%0d_ld", i), bus.ld_data, vt[i].exp);
        chk($sformatf("v%0d_raddr", i), {16'b0, bus.dm_read_addr},
            {16'b0, vt[i].err ? ra0 : vt[i].ea});
      end
      tick();
      chk($sformatf("v%0d_done_1cyc", i), {31'b0, bus.done}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sisc_lsu.md
Name: sisc_lsu

Overview:
- Load/store unit for the SISC processor. It sits directly upstream of the data memory and is the only block that drives it.
- Accepts one load or store request at a time from the control unit and computes the effective address.
- For a load, it drives the memory read address and returns the captured word.
- For a store, it sequences the write-enable pulse. The memory commits a write on the falling edge of its write enable.

Parameters:
- ADDR_W, 16: memory word-address width.
- DATA_W, 32: data word width.
- MAX_ADDR, 65532: highest valid word address; the memory holds entries 0..MAX_ADDR.

Ports:
- clk  in  1  single system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only when busy=0.
- op_st  in  1  1=store, 0=load; sampled with start.
- base  in  DATA_W  base register value; low ADDR_W bits used.
- offset  in  16  signed word offset.
- st_data  in  DATA_W  store data; sampled with start.
- busy  out  1  request in flight.
- done  out  1  one-cycle completion pulse.
- ld_data  out  DATA_W  load result; valid when done=1 for a load.
- addr_err  out  1  effective address > MAX_ADDR; valid with done.
- dm_read_addr  out  ADDR_W  to data memory.
- dm_write_addr  out  ADDR_W  to data memory.
- dm_write_data  out  DATA_W  to data memory.
- dm_we  out  1  to data memory; the write commits on its falling edge.
- dm_read_data  in  DATA_W  from data memory.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE.
- Effective address: EA = base[15:0] + sign_extend(offset), computed modulo 2^16 (wraps, no carry out). EA is registered at the accepting edge E.
- States: IDLE, LD_WAIT, LD_CAP, ST_SET, ST_PULSE, DONE.
- Accepting edge E: start=1 while in IDLE. busy goes 1 after E.
- Load, EA ≤ MAX_ADDR:
  - E → LD_WAIT; dm_read_addr=EA.
  - E+1 → LD_CAP; ld_data ← dm_read_data.
  - E+2 → DONE; done=1, busy=0.
- Load, EA > MAX_ADDR:
  - dm_read_addr is not changed.
  - ld_data=0 and addr_err=1, delivered at the same latency as a valid load.
- Store, EA ≤ MAX_ADDR:
  - E → ST_SET; dm_write_addr=EA, dm_write_data=st_data, dm_we=0.
  - E+1 → ST_PULSE; dm_we=1.
  - E+2 → DONE; dm_we=0, so the memory commits; done=1, busy=0.
  - dm_write_addr and dm_write_data are held stable from E through at least E+3.
- Store, EA > MAX_ADDR:
  - dm_we never asserts; no memory change.
  - addr_err=1; done at E+2.
- DONE: lasts exactly one cycle, then IDLE.
  - A start present during DONE is accepted; that edge is the next E, giving back-to-back operation at 3 cycles per request.
  - ld_data and addr_err hold their values until the next accepted start.
- start while busy=1 is ignored and not queued.
- dm_we is never high for more than one cycle and never high in any state other than ST_PULSE.
- Reset mid-operation:
  - Returns to IDLE and clears outputs to 0, except dm_write_addr and dm_write_data.
  - If dm_we=1 at the reset edge, dm_write_addr and dm_write_data keep their values through that edge. The resulting dm_we fall then commits exactly the requested write, not a corrupted one.
  - No done pulse is issued for an aborted request.

Test Plan:
- Load: memory[5]=0x0000_0007; start with op_st=0, base=0x0000_0003, offset=+2 → dm_read_addr=5 after E. done=1 after E+2 with ld_data=0x0000_0007, addr_err=0.
- Store then load:
  - Store: base=0x10, offset=-1, st_data=0xDEAD_BEEF → dm_we=1 for exactly the cycle after E+1, falls at E+2; memory[0x0F]=0xDEAD_BEEF.
  - Load issued in the DONE cycle to the same address → ld_data=0xDEAD_BEEF at that request's E+2.
- Wrap and range:
  - base=0xFFFF, offset=+1 → EA=0x0000, valid load.
  - base=0xFFFC, offset=+1 → EA=0xFFFD (above MAX_ADDR 0xFFFC). Store: addr_err=1, dm_we stays 0, memory unchanged. Load: ld_data=0, addr_err=1.
- Busy collision: start pulsed at E+1 during a store → ignored. Exactly one done is seen and memory shows a single write.
- Reset during ST_PULSE (dm_we=1): rst at E+2 → dm_we=0, busy=0, done never asserts. memory[EA]=st_data and no other location changes.
